// File: rtl/cavlc_seq_ctrl_if.sv
// cavlc_seq_ctrl_if: codeword beat bus between the CAVLC sequencer and the encoder datapath/packer
interface cavlc_seq_ctrl_if #(parameter int IDX_W = 4);
  logic [3:0] state;
  logic [IDX_W-1:0] coef_idx;
  logic [IDX_W-1:0] zeros_left;
  logic [IDX_W-1:0] run_val;
  logic code_valid;
  logic code_ready;
  modport master(output state, coef_idx, zeros_left, code_valid, input run_val, code_ready);
  modport slave(input state, coef_idx, zeros_left, code_valid, output run_val, code_ready);
endinterface

// File: rtl/cavlc_seq_ctrl.sv
// cavlc_seq_ctrl: per-4x4-block CAVLC phase sequencer (coeff_token, T1 signs, levels, total_zeros, run_before)
module cavlc_seq_ctrl #(
  parameter int MAX_COEFF = 16,
  parameter int IDX_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [2:0] nc,
  input  logic [4:0] total_coeff,
  input  logic [1:0] trail_ones,
  input  logic [3:0] total_zeros,
  output logic [2:0] nc_q,
  output logic [4:0] total_coeff_q,
  output logic [1:0] trail_ones_q,
  output logic busy,
  output logic done,
  output logic err,
  cavlc_seq_ctrl_if.master beat
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, COEFF_TOKEN = 4'd4, T1_SIGN = 4'd5, LEVEL = 4'd6,
    TOTAL_ZEROS = 4'd7, RUN_BEFORE = 4'd8, DONE = 4'd9
  } state_t;
  state_t cur, nxt;
  logic [IDX_W-1:0] idx, idx_n, zl, zl_n, zl_sub;
  logic [3:0] tz_q;
  logic [4:0] idx5, t15, max5;
  logic illegal, accept, accept_bad, fire;
  assign max5 = 5'(MAX_COEFF);
  assign idx5 = 5'(idx);
  assign t15 = 5'(trail_ones_q);
  assign illegal = (5'(trail_ones) > total_coeff) || (total_coeff > max5) ||
                   (6'(total_zeros) + 6'(total_coeff) > 6'(MAX_COEFF));
  assign accept = (cur == IDLE) && start && !illegal;
  assign accept_bad = (cur == IDLE) && start && illegal;
  assign fire = beat.code_valid && beat.code_ready;
  // a run larger than the zeros remaining saturates instead of wrapping
  assign zl_sub = (beat.run_val > zl) ? '0 : zl - beat.run_val;
  assign beat.state = cur;
  assign beat.coef_idx = idx;
  assign beat.zeros_left = zl;
  assign beat.code_valid = cur inside {COEFF_TOKEN, T1_SIGN, LEVEL, TOTAL_ZEROS, RUN_BEFORE};
  assign busy = cur != IDLE;
  assign done = cur == DONE;
  always_comb begin
    nxt = cur;
    idx_n = idx;
    zl_n = zl;
    case (cur)
      IDLE: if (accept) begin
        nxt = COEFF_TOKEN;
        idx_n = '0;
        zl_n = '0;
      end
      COEFF_TOKEN: if (fire) begin
        nxt = (total_coeff_q == 5'd0) ? DONE : (trail_ones_q != 2'd0) ? T1_SIGN : LEVEL;
        idx_n = '0;
      end
      T1_SIGN: if (fire) begin
        nxt = (total_coeff_q > t15) ? LEVEL : TOTAL_ZEROS;
        idx_n = IDX_W'(trail_ones_q);
      end
      LEVEL: if (fire) begin
        idx_n = idx + IDX_W'(1);
        if (idx5 == total_coeff_q - 5'd1) nxt = (total_coeff_q == max5) ? DONE : TOTAL_ZEROS;
      end
      TOTAL_ZEROS: if (fire) begin
        nxt = (tz_q == 4'd0 || total_coeff_q == 5'd1) ? DONE : RUN_BEFORE;
        idx_n = '0;
        zl_n = IDX_W'(tz_q);
      end
      RUN_BEFORE: if (fire) begin
        nxt = (zl_sub == '0 || idx5 == total_coeff_q - 5'd2) ? DONE : RUN_BEFORE;
        idx_n = idx + IDX_W'(1);
        zl_n = zl_sub;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur <= IDLE;
      idx <= '0;
      zl <= '0;
      nc_q <= '0;
      total_coeff_q <= '0;
      trail_ones_q <= '0;
      tz_q <= '0;
      err <= 1'b0;
    end else begin
      cur <= nxt;
      idx <= idx_n;
      zl <= zl_n;
      err <= accept_bad;
      if (accept) begin
        nc_q <= nc;
        total_coeff_q <= total_coeff;
        trail_ones_q <= trail_ones;
        tz_q <= total_zeros;
      end
    end
endmodule

// File: tb/tb_cavlc_seq_ctrl.sv
// tb_cavlc_seq_ctrl: directed blocks checked every cycle against an expected-beat-list model
module tb_cavlc_seq_ctrl;
  logic clk = 0, rst = 1, start = 0, ready = 1;
  logic [2:0] nc = 0;
  logic [4:0] total_coeff = 0;
  logic [1:0] trail_ones = 0;
  logic [3:0] total_zeros = 0;
  logic [2:0] nc_q;
  logic [4:0] total_coeff_q;
  logic [1:0] trail_ones_q;
  logic busy, done, err;
  logic [3:0] runs [16];
  cavlc_seq_ctrl_if #(.IDX_W(4)) beat();
  cavlc_seq_ctrl #(.MAX_COEFF(16), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .nc(nc), .total_coeff(total_coeff),
    .trail_ones(trail_ones), .total_zeros(total_zeros), .nc_q(nc_q),
    .total_coeff_q(total_coeff_q), .trail_ones_q(trail_ones_q),
    .busy(busy), .done(done), .err(err), .beat(beat.master)
  );
  always #5 clk = ~clk;
  assign beat.run_val = runs[beat.coef_idx];
  assign beat.code_ready = ready;
  typedef struct packed {logic [3:0] st; logic [3:0] idx; logic [3:0] zl;} beat_t;
  beat_t q[$];
  int checks = 0, failures = 0, beat_cnt = 0;
  logic active = 0, exp_done = 0, exp_err = 0, m_rb = 0;
  logic [2:0] m_nc;
  logic [4:0] m_tc;
  logic [1:0] m_t1;
  logic [3:0] m_zl_final;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic beat_t mk(input int s, input int i, input int z);
    return beat_t'{4'(s), 4'(i), 4'(z)};
  endfunction
  // expected beat list derived from the phase rules of the block statistics
  function automatic void build(input int tc, input int t1, input int tz);
    int zl;
    q.delete();
    m_rb = 0;
    q.push_back(mk(4, 0, 0));
    if (tc == 0) return;
    if (t1 > 0) q.push_back(mk(5, 0, 0));
    for (int i = t1; i < tc; i++) q.push_back(mk(6, i, 0));
    if (tc == 16) return;
    q.push_back(mk(7, 0, 0));
    if (tz == 0 || tc == 1) return;
    m_rb = 1;
    zl = tz;
    for (int i = 0; i < tc - 1; i++) begin
      q.push_back(mk(8, i, zl));
      zl = (int'(runs[i]) > zl) ? 0 : zl - int'(runs[i]);
      if (zl == 0) break;
    end
    m_zl_final = 4'(zl);
  endfunction
  task automatic set_runs(input logic [63:0] pat);
    for (int i = 0; i < 16; i++) runs[i] = pat[4*i +: 4];
  endtask
  task automatic go(input int n, input int tc, input int t1, input int tz);
    @(posedge clk); #1;
    nc = 3'(n); total_coeff = 5'(tc); trail_ones = 2'(t1); total_zeros = 4'(tz); start = 1;
    @(posedge clk); #1;
    start = 0;
    build(tc, t1, tz);
    m_nc = 3'(n); m_tc = 5'(tc); m_t1 = 2'(t1);
    beat_cnt = 0;
    active = 1;
  endtask
  task automatic bad(input int tc, input int t1, input int tz);
    @(posedge clk); #1;
    total_coeff = 5'(tc); trail_ones = 2'(t1); total_zeros = 4'(tz); start = 1;
    @(posedge clk); #1;
    start = 0;
    exp_err = 1;
    repeat (3) @(posedge clk);
  endtask
  task automatic wait_idle(input string name);
    int i = 0;
    while ((active || exp_done) && i < 300) begin @(posedge clk); i++; end
    #1;
    check({name, "_timeout"}, 32'(active || exp_done), 0);
    active = 0; exp_done = 0; q.delete();
  endtask
  task automatic wait_state(input int s);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (beat.state == 4'(s)) break;
    end
    check("reach_state", 32'(beat.state), 32'(s));
  endtask
  // per-cycle comparison of the DUT against the model
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("busy", 32'(busy), 32'(active || exp_done));
      check("done", 32'(done), 32'(exp_done));
      check("err", 32'(err), 32'(exp_err));
      exp_err = 0;
      if (exp_done) begin
        check("done_state", 32'(beat.state), 9);
        check("done_valid", 32'(beat.code_valid), 0);
        if (m_rb) check("zl_final", 32'(beat.zeros_left), 32'(m_zl_final));
        exp_done = 0;
        active = 0;
      end else if (active) begin
        if (q.size() == 0) begin
          check("beat_underflow", 32'(beat.code_valid), 0);
          active = 0;
        end else begin
          check("code_valid", 32'(beat.code_valid), 1);
          check("state", 32'(beat.state), 32'(q[0].st));
          if (q[0].st inside {4'd5, 4'd6, 4'd8}) check("coef_idx", 32'(beat.coef_idx), 32'(q[0].idx));
          if (q[0].st == 4'd8) check("zeros_left", 32'(beat.zeros_left), 32'(q[0].zl));
          check("nc_q", 32'(nc_q), 32'(m_nc));
          check("total_coeff_q", 32'(total_coeff_q), 32'(m_tc));
          check("trail_ones_q", 32'(trail_ones_q), 32'(m_t1));
          if (beat.code_valid && ready) beat_cnt++;
          if (ready) begin
            void'(q.pop_front());
            if (q.size() == 0) exp_done = 1;
          end
        end
      end else begin
        check("idle_valid", 32'(beat.code_valid), 0);
        check("idle_state", 32'(beat.state), 0);
      end
    end
  end
  initial begin
    set_runs(64'h0);
    #2;
    check("rst_state", 32'(beat.state), 0);
    check("rst_valid", 32'(beat.code_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_q", 32'({nc_q, total_coeff_q, trail_ones_q}), 0);
    check("rst_idx_zl", 32'({beat.coef_idx, beat.zeros_left}), 0);
    @(posedge clk); #1 rst = 0;
    // standard block, with the model pinned to hand-derived values
    set_runs(64'h1101);
    go(2, 5, 3, 3);
    check("std_len", 32'(q.size()), 9);
    check("std_states", {q[0].st, q[1].st, q[2].st, q[3].st, q[4].st, q[5].st, q[6].st, q[7].st}, 32'h45667888);
    check("std_last", 32'(q[8].st), 8);
    check("std_lvl_idx", {q[2].idx, q[3].idx}, 32'h34);
    check("std_rb_zl", {q[5].zl, q[6].zl, q[7].zl, q[8].zl, m_zl_final}, 32'h32210);
    wait_idle("std");
    check("std_beats", 32'(beat_cnt), 9);
    go(1, 0, 0, 0);
    check("empty_len", 32'(q.size()), 1);
    wait_idle("empty");
    go(5, 16, 0, 0);
    check("full_len", 32'(q.size()), 17);
    check("full_last_idx", 32'(q[16].idx), 15);
    wait_idle("full");
    // back-pressure during the first LEVEL beat
    set_runs(64'h1101);
    go(3, 5, 3, 3);
    wait_state(6);
    ready = 0;
    repeat (3) @(posedge clk);
    #1 ready = 1;
    wait_idle("stall");
    check("stall_beats", 32'(beat_cnt), 9);
    bad(2, 3, 0);
    bad(17, 0, 0);
    bad(10, 0, 7);
    set_runs(64'h31020);
    go(4, 10, 2, 6);
    wait_idle("edge_tz");
    go(0, 1, 1, 5);
    check("single_len", 32'(q.size()), 3);
    wait_idle("single");
    set_runs(64'h3);
    go(6, 4, 0, 2);
    check("sat_len", 32'(q.size()), 7);
    wait_idle("sat");
    go(7, 3, 1, 0);
    wait_idle("tz0");
    // asynchronous reset in the middle of RUN_BEFORE
    set_runs(64'h1101);
    go(2, 5, 3, 3);
    wait_state(8);
    active = 0; exp_done = 0; q.delete();
    rst = 1;
    #1;
    check("mid_rst_state", 32'(beat.state), 0);
    check("mid_rst_valid", 32'(beat.code_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_q", 32'({nc_q, total_coeff_q, trail_ones_q, beat.coef_idx, beat.zeros_left}), 0);
    @(posedge clk); #1 rst = 0;
    repeat (2) @(posedge clk);
    // start while busy and during DONE must both be ignored
    go(1, 5, 3, 3);
    total_coeff = 0; trail_ones = 0; nc = 0; start = 1;
    @(posedge clk); #1 start = 0;
    wait_state(9);
    start = 1;
    @(posedge clk); #1 start = 0;
    wait_idle("restart");
    repeat (4) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cavlc_seq_ctrl.md
Name: cavlc_seq_ctrl

Overview:
- Per-4x4-block sequencer for the CAVLC entropy encoder.
- Takes block statistics from the coefficient scan stage and steps the encoder datapath through five phases: coeff_token, trailing-ones signs, levels, total_zeros and run_before.
- Drives the 4-bit `state` select of the Coeff_token_enc and sibling encoders, indexes the coefficient buffer, and emits one codeword beat per handshake to the bitstream packer.

Parameters:
- MAX_COEFF, 16, coefficients per block (16 for a 4x4 luma block).
- IDX_W, 4, width of the coefficient index and zeros counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a block; sampled only in IDLE.
- nc  in  3  neighbour-context class for coeff_token table select.
- total_coeff  in  5  number of nonzero coefficients in the block.
- trail_ones  in  2  number of trailing ±1 coefficients, 0..3.
- total_zeros  in  4  zeros before the last nonzero coefficient.
- run_val  in  4  run_before of the coefficient at coef_idx; combinational from the buffer.
- code_ready  in  1  packer accepts the current beat.
- state  out  4  encoder phase select.
- nc_q  out  3  latched nc.
- total_coeff_q  out  5  latched total_coeff.
- trail_ones_q  out  2  latched trail_ones.
- coef_idx  out  IDX_W  index of the coefficient currently being encoded.
- zeros_left  out  IDX_W  remaining zeros during RUN_BEFORE.
- code_valid  out  1  current beat is valid.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at block end.
- err  out  1  one-cycle pulse on illegal block statistics.

Behaviour:
- **State encoding:** IDLE=0, COEFF_TOKEN=4, T1_SIGN=5, LEVEL=6, TOTAL_ZEROS=7, RUN_BEFORE=8, DONE=9. All other codes return to IDLE on the next clock.
- **Reset:** state=IDLE. All *_q outputs, coef_idx, zeros_left, code_valid, busy, done and err are 0.
- **Start acceptance:** start is accepted only in IDLE. The cycle after acceptance, nc, total_coeff, trail_ones and total_zeros are latched and state=COEFF_TOKEN with code_valid=1. start while busy is ignored.
- **Illegal inputs:** if trail_ones > total_coeff, or total_coeff > MAX_COEFF, or total_zeros > MAX_COEFF - total_coeff:
  - err pulses for 1 cycle;
  - state stays IDLE;
  - no beats are emitted.
- **Beat handshake:**
  - A beat completes on a clk edge with code_valid && code_ready.
  - While code_ready=0, state, coef_idx, zeros_left and code_valid hold.
  - code_valid is 1 in every phase state and 0 in IDLE and DONE.
- **COEFF_TOKEN:** 1 beat. Next state:
  - total_coeff_q=0 → DONE;
  - else trail_ones_q>0 → T1_SIGN;
  - else → LEVEL.
- **T1_SIGN:** 1 beat carrying all trail_ones_q signs; coef_idx=0 during it. Next state:
  - total_coeff_q > trail_ones_q → LEVEL, with coef_idx=trail_ones_q;
  - else → TOTAL_ZEROS.
- **LEVEL:** one beat per coefficient, coef_idx running trail_ones_q .. total_coeff_q-1, incrementing per beat.
  - Entry from COEFF_TOKEN sets coef_idx=0.
  - After the beat at index total_coeff_q-1 → TOTAL_ZEROS.
- **TOTAL_ZEROS:** 1 beat, skipped when total_coeff_q == MAX_COEFF.
  - On exit, zeros_left=total_zeros and coef_idx=0.
  - If total_zeros=0 or total_coeff_q=1 → DONE; else → RUN_BEFORE.
- **RUN_BEFORE:** one beat per coefficient.
  - On each beat: zeros_left -= run_val, coef_idx += 1.
  - Leave to DONE after the beat where the new zeros_left=0, or where coef_idx was total_coeff_q-2.
  - run_val > zeros_left: zeros_left saturates to 0 and the block ends normally; no err.
- **DONE:** 1 cycle with done=1 and busy=1, then IDLE.
  - A start asserted in the DONE cycle is ignored.
  - Earliest next accept is the first IDLE cycle.
- **Mid-operation reset:** rst mid-block returns immediately to the reset values. No done pulse and no partial state are retained.
- **Widths:** coef_idx and zeros_left are unsigned IDX_W. total_coeff_q compares use 5-bit unsigned arithmetic.

Test Plan:
- **Standard block:** reset, then start with total_coeff=5, trail_ones=3, total_zeros=3, run_val sequence 1,0,1,1, code_ready=1.
  - Required: exactly 9 beats with states 4, 5, 6, 6, 7, 8, 8, 8, 8.
  - coef_idx in LEVEL is 3 then 4.
  - zeros_left after each RUN_BEFORE beat is 2, 2, 1, 0.
  - done pulses on the cycle after the last beat.
- **Empty block:** total_coeff=0 → one COEFF_TOKEN beat, then DONE; no other states are visited.
- **Full block:** total_coeff=16, trail_ones=0, total_zeros=0 → 1 COEFF_TOKEN beat, 16 LEVEL beats (coef_idx 0..15), TOTAL_ZEROS skipped, then DONE.
- **Back-pressure:** same stimulus as the standard block, with code_ready low for 3 cycles during the first LEVEL beat.
  - state, coef_idx and code_valid are unchanged during the stall.
  - Total beat count is still 9.
- **Illegal statistics:** trail_ones=3, total_coeff=2 → err=1 for 1 cycle, busy stays 0, no code_valid.
- **Reset mid-operation:** rst asserted during RUN_BEFORE → state=0 and code_valid=0 immediately; done never pulses. A following start is accepted normally.
